// File: rtl/inst_buffer_pkg.sv
// Shared types and default widths for the fetch -> instruction buffer -> decode path.
package inst_buffer_pkg;

    localparam int unsigned FETCH_WIDTH  = 4;
    localparam int unsigned DECODE_WIDTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } InstBufEntrySt;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the instruction buffer.
interface inst_buffer_if
    import inst_buffer_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH  = inst_buffer_pkg::FETCH_WIDTH,
    parameter int unsigned DECODE_WIDTH = inst_buffer_pkg::DECODE_WIDTH
);
    localparam int unsigned NUM_W = $clog2(FETCH_WIDTH + 1);

    logic                          fetch_valid;
    logic                          fetch_ready;
    logic [NUM_W-1:0]              fetch_num;
    logic [FETCH_WIDTH-1:0][31:0]  fetch_pc;
    logic [FETCH_WIDTH-1:0][31:0]  fetch_instr;

    logic [DECODE_WIDTH-1:0]       dec_valid;
    logic [DECODE_WIDTH-1:0][31:0] dec_pc;
    logic [DECODE_WIDTH-1:0][31:0] dec_instr;
    logic                          dec_ready;

    // Pipeline side: fetch produces packets, decode consumes lanes.
    modport master (
        output fetch_valid, fetch_num, fetch_pc, fetch_instr, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, dec_instr
    );

    modport slave (
        input  fetch_valid, fetch_num, fetch_pc, fetch_instr, dec_ready,
        output fetch_ready, dec_valid, dec_pc, dec_instr
    );

endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer: multi-lane push from fetch, in-order multi-lane read to decode,
// single-cycle flush.
module inst_buffer #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned FETCH_WIDTH  = inst_buffer_pkg::FETCH_WIDTH,
    parameter int unsigned DECODE_WIDTH = inst_buffer_pkg::DECODE_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    inst_buffer_if.slave bus
);
    import inst_buffer_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned NUM_W = $clog2(FETCH_WIDTH + 1);

    InstBufEntrySt           r_mem [DEPTH];
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;

    logic                    w_fetch_ready;
    logic                    w_push;
    logic                    w_pop;
    logic [CNT_W-1:0]        w_push_num;
    logic [CNT_W-1:0]        w_pop_num;
    logic [DECODE_WIDTH-1:0] w_dec_valid;

    // Ready depends only on the registered count, so a same-cycle pop never helps.
    assign w_fetch_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_WIDTH);
    assign w_push        = bus.fetch_valid & w_fetch_ready & ~flush;
    assign w_pop         = bus.dec_ready & ~flush;
    assign w_push_num    = w_push ? CNT_W'(bus.fetch_num) : '0;

    always_comb begin
        w_dec_valid = '0;
        w_pop_num   = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            w_dec_valid[i] = r_count > CNT_W'(i);
            if (w_dec_valid[i]) begin
                w_pop_num = w_pop_num + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.dec_pc    = '0;
        bus.dec_instr = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            bus.dec_pc[i]    = r_mem[r_head + PTR_W'(i)].pc;
            bus.dec_instr[i] = r_mem[r_head + PTR_W'(i)].instr;
        end
    end

    assign bus.fetch_ready = w_fetch_ready;
    assign bus.dec_valid   = w_dec_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(bus.fetch_num);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(w_pop_num);
            end
            r_count <= r_count + w_push_num - (w_pop ? w_pop_num : '0);
        end
    end

    // Push only ever targets free slots, so it never collides with the lanes being read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (NUM_W'(i) < bus.fetch_num) begin
                    r_mem[r_tail + PTR_W'(i)] <= '{pc: bus.fetch_pc[i], instr: bus.fetch_instr[i]};
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer with DEPTH=16, FETCH_WIDTH=4, DECODE_WIDTH=2.
module tb_inst_buffer;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   vectors     = 0;
    int   miscompares = 0;

    inst_buffer_if #(.FETCH_WIDTH(4), .DECODE_WIDTH(2)) bus ();

    inst_buffer #(
        .DEPTH        (16),
        .FETCH_WIDTH  (4),
        .DECODE_WIDTH (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h0013_5a5a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_packet(input logic v, input int n, input logic [31:0] base);
        assert (n <= 4) else $fatal(1, "FAIL fetch_num %0d exceeds fetch width", n);
        bus.fetch_valid = v;
        bus.fetch_num   = 3'(n);
        for (int i = 0; i < 4; i++) begin
            bus.fetch_pc[i]    = base + 32'(4 * i);
            bus.fetch_instr[i] = instr_of(base + 32'(4 * i));
        end
    endtask

    task automatic push(input int n, input logic [31:0] base);
        set_packet(1'b1, n, base);
        tick();
        bus.fetch_valid = 1'b0;
    endtask

    task automatic check_lanes(input string tag, input logic [1:0] valid, input logic [31:0] pc0);
        check({tag, "/valid"}, 32'(bus.dec_valid), 32'(valid));
        if (valid[0]) begin
            check({tag, "/pc0"}, bus.dec_pc[0], pc0);
            check({tag, "/instr0"}, bus.dec_instr[0], instr_of(pc0));
        end
        if (valid[1]) begin
            check({tag, "/pc1"}, bus.dec_pc[1], pc0 + 32'd4);
            check({tag, "/instr1"}, bus.dec_instr[1], instr_of(pc0 + 32'd4));
        end
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_num   = '0;
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.dec_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and first packet
        check("rst/fetch_ready", 32'(bus.fetch_ready), 32'd1);
        check_lanes("rst", 2'b00, 32'd0);
        rst = 1'b0;
        push(4, 32'h1c00_0000);
        check_lanes("t1/first", 2'b11, 32'h1c00_0000);
        bus.dec_ready = 1'b1;
        tick();
        check_lanes("t1/second", 2'b11, 32'h1c00_0008);
        tick();
        check_lanes("t1/empty", 2'b00, 32'd0);
        tick();
        check_lanes("t1/idle_pop", 2'b00, 32'd0);

        // Odd fill drained at two per cycle
        push(3, 32'h2000_0000);
        check_lanes("t2/pair", 2'b11, 32'h2000_0000);
        tick();
        check_lanes("t2/single", 2'b01, 32'h2000_0008);
        tick();
        check_lanes("t2/empty", 2'b00, 32'd0);

        // Fill to full, rejected packet, drain
        bus.dec_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            push(4, 32'h3000_0000 + 32'(16 * p));
            check("t3/fetch_ready", 32'(bus.fetch_ready), (p < 3) ? 32'd1 : 32'd0);
        end
        set_packet(1'b1, 4, 32'h3f00_0000);
        tick();
        bus.fetch_valid = 1'b0;
        check_lanes("t3/held", 2'b11, 32'h3000_0000);
        check("t3/still_full", 32'(bus.fetch_ready), 32'd0);
        bus.dec_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_lanes("t3/drain", (k < 8) ? 2'b11 : 2'b00, 32'h3000_0000 + 32'(8 * k));
            if (k == 1) check("t3/ready_at_14", 32'(bus.fetch_ready), 32'd0);
            if (k == 2) check("t3/ready_at_12", 32'(bus.fetch_ready), 32'd1);
        end

        // count=13: not ready even with a same-cycle pop
        bus.dec_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            push(4, 32'h5000_0000 + 32'(16 * p));
        end
        push(1, 32'h5000_0030);
        check("t3b/ready_at_13", 32'(bus.fetch_ready), 32'd0);
        set_packet(1'b1, 4, 32'h5f00_0000);
        bus.dec_ready = 1'b1;
        tick();
        bus.fetch_valid = 1'b0;
        check("t3b/ready_at_11", 32'(bus.fetch_ready), 32'd1);
        check_lanes("t3b/head", 2'b11, 32'h5000_0008);
        tick();
        check_lanes("t3b/count9", 2'b11, 32'h5000_0010);

        // Flush at count=9 with a simultaneous push and pop
        flush = 1'b1;
        set_packet(1'b1, 4, 32'h6000_0000);
        tick();
        flush           = 1'b0;
        bus.fetch_valid = 1'b0;
        check_lanes("t5/flushed", 2'b00, 32'd0);
        check("t5/fetch_ready", 32'(bus.fetch_ready), 32'd1);
        tick();
        check_lanes("t5/no_ghost", 2'b00, 32'd0);
        push(2, 32'h6100_0000);
        check_lanes("t5/refill", 2'b11, 32'h6100_0000);
        tick();
        check_lanes("t5/drained", 2'b00, 32'd0);

        // Wrap-around: 20 pushes at 4/cycle, pops at 2/cycle
        for (int k = 1; k <= 11; k++) begin
            if (k <= 5) set_packet(1'b1, 4, 32'h7000_0000 + 32'(16 * (k - 1)));
            else        bus.fetch_valid = 1'b0;
            tick();
            check_lanes("t4/wrap", (k <= 10) ? 2'b11 : 2'b00, 32'h7000_0000 + 32'(8 * (k - 1)));
        end
        bus.fetch_valid = 1'b0;

        // Asynchronous reset between edges at count=6
        bus.dec_ready = 1'b0;
        push(4, 32'h8000_0000);
        push(2, 32'h8000_0010);
        check_lanes("t6/pre", 2'b11, 32'h8000_0000);
        #3;
        rst = 1'b1;
        #1;
        check_lanes("t6/async", 2'b00, 32'd0);
        check("t6/fetch_ready", 32'(bus.fetch_ready), 32'd1);
        #1;
        rst = 1'b0;
        push(4, 32'h9000_0000);
        check_lanes("t6/after", 2'b11, 32'h9000_0000);
        bus.dec_ready = 1'b1;
        tick();
        check_lanes("t6/second", 2'b11, 32'h9000_0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
